// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: Mealy match on a programmable PAT_LEN-bit
// pattern, with a registered match copy and a saturating match counter.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           din,
    input  logic                           overlap,
    input  logic                           load_pat,
    input  logic [PAT_LEN-1:0]             pat_in,
    input  logic                           clr_count,
    output logic                           match,
    output logic                           match_q,
    output logic [CNT_W-1:0]               match_count,
    output logic [$clog2(PAT_LEN+1)-1:0]   fill,
    output logic [PAT_LEN-1:0]             pattern
);

    localparam int                FW         = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]     FILL_ARMED = FW'(PAT_LEN);
    localparam logic [FW-1:0]     FILL_READY = FW'(PAT_LEN - 1);
    localparam logic [FW-1:0]     FILL_ONE   = {{(FW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [PAT_LEN-2:0] HIST_ZERO = {(PAT_LEN-1){1'b0}};
    localparam logic [FW-1:0]     FILL_ZERO  = {FW{1'b0}};

    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match_dly_q;
    logic [PAT_LEN-1:0] window_s;
    logic               match_s;

    // Candidate window is the stored history plus the bit arriving this cycle.
    always_comb begin
        window_s = {hist_q, din};
        match_s  = en & ~load_pat & (fill_q >= FILL_READY) & (window_s == pattern_q);
    end

    // Next-state for pattern, history and fill; load_pat wins over en.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (load_pat) begin
            pattern_d = pat_in;
            hist_d    = HIST_ZERO;
            fill_d    = FILL_ZERO;
        end else if (en) begin
            if (match_s && !overlap) begin
                hist_d = HIST_ZERO;
                fill_d = FILL_ZERO;
            end else begin
                hist_d = window_s[PAT_LEN-2:0];
                fill_d = (fill_q == FILL_ARMED) ? fill_q : (fill_q + FILL_ONE);
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // Saturating match counter; a clear beats a coincident match.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = CNT_ZERO;
        end else if (match_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset reloads the build-time pattern, not the last pat_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q   <= PATTERN;
            hist_q      <= HIST_ZERO;
            fill_q      <= FILL_ZERO;
            count_q     <= CNT_ZERO;
            match_dly_q <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            match_dly_q <= match_s;
        end
    end

    assign match       = match_s;
    assign match_q     = match_dly_q;
    assign match_count = count_q;
    assign fill        = fill_q;
    assign pattern     = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, din = 1'b0, overlap = 1'b0, load_pat = 1'b0, clr_count = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       match, match_q, match2, match_q2;
    logic [7:0] match_count;
    logic [1:0] count2;
    logic [2:0] fill, fill2;
    logic [3:0] pattern, pattern2;
    int         errors = 0;
    int         checks = 0;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
        .load_pat(load_pat), .pat_in(pat_in), .clr_count(clr_count),
        .match(match), .match_q(match_q), .match_count(match_count),
        .fill(fill), .pattern(pattern)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
        .load_pat(load_pat), .pat_in(pat_in), .clr_count(clr_count),
        .match(match2), .match_q(match_q2), .match_count(count2),
        .fill(fill2), .pattern(pattern2)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic d, input logic ov, input logic ld,
                         input logic [3:0] p, input logic c);
        en = e; din = d; overlap = ov; load_pat = ld; pat_in = p; clr_count = c;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Clears history, fill and counters while loading the given pattern.
    task automatic prep(input logic [3:0] p);
        drive(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b1);
        cyc();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (pattern !== 4'b1101) begin errors++; $display("FAIL rst_pattern: got %b expected 1101", pattern); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", match_count); end
        checks++; if (match_q !== 1'b0) begin errors++; $display("FAIL rst_match_q: got %b expected 0", match_q); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL rst_match: got %b expected 0", match); end
        cyc();
        cyc();
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_hold_fill: got %0d expected 0", fill); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        cyc();
    endtask

    task automatic test_overlap();
        logic s [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic m [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        prep(4'b1101);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== m[i]) begin errors++; $display("FAIL ovl_match[%0d]: got %b expected %b", i, match, m[i]); end
            cyc();
            checks++; if (match_q !== m[i]) begin errors++; $display("FAIL ovl_match_q[%0d]: got %b expected %b", i, match_q, m[i]); end
        end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_count: got %0d expected 2", match_count); end
    endtask

    task automatic test_nonoverlap();
        logic s [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic m [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int   f [7] = '{1, 2, 3, 0, 1, 2, 3};
        prep(4'b1101);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== m[i]) begin errors++; $display("FAIL novl_match[%0d]: got %b expected %b", i, match, m[i]); end
            cyc();
            checks++; if (fill !== 3'(f[i])) begin errors++; $display("FAIL novl_fill[%0d]: got %0d expected %0d", i, fill, f[i]); end
        end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL novl_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_gaps();
        logic e [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic d [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic m [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   f [7] = '{1, 2, 2, 2, 2, 3, 4};
        prep(4'b1101);
        for (int i = 0; i < 7; i++) begin
            drive(e[i], d[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== m[i]) begin errors++; $display("FAIL gap_match[%0d]: got %b expected %b", i, match, m[i]); end
            cyc();
            checks++; if (fill !== 3'(f[i])) begin errors++; $display("FAIL gap_fill[%0d]: got %0d expected %0d", i, fill, f[i]); end
        end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL gap_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_load();
        logic s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic n [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        prep(4'b1101);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s[i], 1'b0, 1'b0, 4'b0000, 1'b0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            cyc();
        end
        checks++; if (fill !== 3'd3) begin errors++; $display("FAIL load_prefill: got %0d expected 3", fill); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL load_match: got %b expected 0", match); end
        cyc();
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL load_fill: got %0d expected 0", fill); end
        checks++; if (pattern !== 4'b0110) begin errors++; $display("FAIL load_pattern: got %b expected 0110", pattern); end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL load_count: got %0d expected 1", match_count); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, n[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== (i == 3)) begin errors++; $display("FAIL load_new[%0d]: got %b expected %b", i, match, (i == 3)); end
            cyc();
        end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL load_count2: got %0d expected 2", match_count); end
        prep(4'b0110);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== 1'b0) begin errors++; $display("FAIL load_old[%0d]: got %b expected 0", i, match); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        logic s [3] = '{1'b1, 1'b1, 1'b0};
        prep(4'b0110);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (pattern !== 4'b1101) begin errors++; $display("FAIL mid_rst_pattern: got %b expected 1101", pattern); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL mid_rst_fill: got %0d expected 0", fill); end
        cyc();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL mid_match: got %b expected 0", match); end
        cyc();
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL mid_fill: got %0d expected 1", fill); end
        checks++; if (pattern !== 4'b1101) begin errors++; $display("FAIL mid_pattern: got %b expected 1101", pattern); end
    endtask

    task automatic test_saturate();
        logic t [3] = '{1'b1, 1'b0, 1'b1};
        int   n;
        prep(4'b1101);
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, (i % 3 != 2), 1'b1, 1'b0, 4'b0000, 1'b0);
            checks++; if (match !== (i % 3 == 0 && i > 0)) begin errors++; $display("FAIL sat_match[%0d]: got %b expected %b", i, match, (i % 3 == 0 && i > 0)); end
            cyc();
            n = i / 3;
            checks++; if (count2 !== 2'((n > 3) ? 3 : n)) begin errors++; $display("FAIL sat_count2[%0d]: got %0d expected %0d", i, count2, (n > 3) ? 3 : n); end
        end
        checks++; if (match_count !== 8'd4) begin errors++; $display("FAIL sat_count8: got %0d expected 4", match_count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, t[i], 1'b1, 1'b0, 4'b0000, (i == 2));
            checks++; if (match !== (i == 2)) begin errors++; $display("FAIL sat_tail_match[%0d]: got %b expected %b", i, match, (i == 2)); end
            cyc();
        end
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL sat_clr2: got %0d expected 0", count2); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL sat_clr8: got %0d expected 0", match_count); end
    endtask

    task automatic test_random();
        logic [3:0] m_pat;
        logic       q [$];
        int         m_c8, m_c2;
        logic       e, d, ov, ld, c, exp_m;
        logic [3:0] p;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_pat = 4'b1101;
        q.delete();
        m_c8 = 0;
        m_c2 = 0;
        for (int i = 0; i < 500; i++) begin
            e  = ($urandom_range(3) != 0);
            d  = 1'($urandom_range(1));
            ov = 1'($urandom_range(1));
            ld = ($urandom_range(39) == 0);
            c  = ($urandom_range(49) == 0);
            p  = 4'($urandom_range(15));
            drive(e, d, ov, ld, p, c);
            exp_m = 1'b0;
            if (e && !ld && q.size() >= 3) begin
                exp_m = ({q[q.size()-3], q[q.size()-2], q[q.size()-1], d} == m_pat);
            end
            checks++; if (match !== exp_m) begin errors++; $display("FAIL rnd_match[%0d]: got %b expected %b", i, match, exp_m); end
            cyc();
            if (c) begin
                m_c8 = 0;
                m_c2 = 0;
            end else if (exp_m) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
            end
            if (ld) begin
                m_pat = p;
                q.delete();
            end else if (e) begin
                if (exp_m && !ov) begin
                    q.delete();
                end else begin
                    q.push_back(d);
                    if (q.size() > 4) void'(q.pop_front());
                end
            end
            checks++; if (match_q !== exp_m) begin errors++; $display("FAIL rnd_match_q[%0d]: got %b expected %b", i, match_q, exp_m); end
            checks++; if (fill !== 3'(q.size())) begin errors++; $display("FAIL rnd_fill[%0d]: got %0d expected %0d", i, fill, q.size()); end
            checks++; if (match_count !== 8'(m_c8)) begin errors++; $display("FAIL rnd_count8[%0d]: got %0d expected %0d", i, match_count, m_c8); end
            checks++; if (count2 !== 2'(m_c2)) begin errors++; $display("FAIL rnd_count2[%0d]: got %0d expected %0d", i, count2, m_c2); end
            checks++; if (pattern !== m_pat) begin errors++; $display("FAIL rnd_pattern[%0d]: got %b expected %b", i, pattern, m_pat); end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_load();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial-pattern detector: the next generation of the team's fixed 4-bit Mealy sequence detector. Detects a programmable PAT_LEN-bit pattern on a 1-bit serial input qualified by an enable. Supports runtime-selectable overlapping or non-overlapping detection. Provides a combinational Mealy match pulse, a registered copy and a saturating match counter. Sits between the debounced push-button/serial-input front end and the display/counter logic.

Parameters:
PAT_LEN, 4, pattern length in bits (legal range 2..16)
PATTERN, 4'b1101, reset value of the pattern register; MSB is the oldest bit
CNT_W, 8, match counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
en  input  1  din valid this cycle; bits are accepted only when en=1
din  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
load_pat  input  1  load pat_in into the pattern register
pat_in  input  PAT_LEN  new pattern; MSB is the oldest bit
clr_count  input  1  synchronous clear of match_count
match  output  1  Mealy match, combinational, same cycle as the completing bit
match_q  output  1  match registered, one cycle later
match_count  output  CNT_W  saturating count of matches
fill  output  clog2(PAT_LEN+1)  number of valid bits in history, saturates at PAT_LEN
pattern  output  PAT_LEN  current pattern register

Behaviour:
- Reset (async, asserted): pattern=PATTERN, hist=0, fill=0, match_count=0, match_q=0. match is then 0 because fill=0 and PAT_LEN>=2.
- Internal state: hist (PAT_LEN-1 bits, shift register of accepted bits, newest in LSB) and fill counter. The fill counter acts as a progress FSM: EMPTY (0), FILLING (1..PAT_LEN-1), ARMED (PAT_LEN).
- match = en & ~load_pat & (fill >= PAT_LEN-1) & ({hist[PAT_LEN-2:0], din} == pattern). Purely combinational in PS and inputs; no latch.
- On a clock edge with en=1 and load_pat=0:
  - hist shifts left and takes din.
  - fill increments, saturating at PAT_LEN.
  - If match=1 and overlap=0: hist and fill clear to 0. The next match needs PAT_LEN fresh bits.
  - If match=1 and overlap=1: the shift proceeds normally and the suffix is reused.
- en=0: hist, fill and pattern hold; match=0. Gaps are transparent to the sequence.
- load_pat=1 has priority over en:
  - pattern<=pat_in; hist<=0; fill<=0.
  - din is discarded and match is forced to 0 that cycle.
  - match_count is unaffected.
- match_q <= match every cycle; latency 1.
- match_count increments by 1 on each cycle with match=1 and holds at all-ones (2^CNT_W-1).
  - clr_count=1 forces 0; clear beats a simultaneous match.
- overlap may change on any cycle. It only affects the clear decision at a matching edge and is sampled on that edge.
- Reset mid-sequence aborts any partial match and reloads PATTERN, not the last pat_in.

Test Plan:
- Default pattern 1101, overlap=1, en=1, din=1,1,0,1,1,0,1 -> match high on bits 4 and 7; match_q high on the cycles after them; match_count=2.
- Same stream with overlap=0 -> match only on bit 4; bits 5-7 (101) plus 1 more needed; match_count=1; fill=0 after bit 4.
- din=1,1,0,1 with en=0 for 3 cycles between bits 2 and 3 -> match on bit 4 only; no match and no fill change during the gaps.
- load_pat with pat_in=0110 while fill=3, then stream 0,1,1,0 -> load cycle gives match=0 and fill=0; match on the 4th bit; old pattern 1101 is no longer detected.
- CNT_W=2, overlap=1, stream of 1101101101101 -> match_count reaches 3 and holds. Then clr_count asserted together with a match -> match_count=0.
- Stream 1,1,0, assert reset for 1 cycle, then 1 -> no match; fill=1 after the final bit; pattern=1101 after reset.
